psum_out_buffer: RTL and testbench
==================================

// Module: psum_out_buffer
// PURPOSE
//  Output FIFO directly downstream of the PE datapath. Captures each completed
//  partial sum (module_outval) on outbuf_write and returns outbuf_full for stalling.
//  Presents results first-word-fall-through to the next stage (memory writer or next PE).
//  Uses a valid/ready handshake on that side.
// PARAMETERS
//  DATA_WIDTH  17  psum width; equals IF_SCRATCH_WIDTH+FILT_SCRATCH_WIDTH+1
//  DEPTH       8   number of entries, >=2, need not be a power of two
//  ADDR_LEN    3   pointer width, ceil(log2(DEPTH))
//  AF_MARGIN   2   almost_full asserts when count >= DEPTH-AF_MARGIN
// PORTS
//  clk           in   1             rising-edge clock
//  rst           in   1             async reset, active-low (asserted at 0)
//  clr           in   1             sync flush of all contents
//  outbuf_write  in   1             write strobe from PE datapath
//  din           in   DATA_WIDTH    psum from PE datapath (module_outval)
//  outbuf_full   out  1             count == DEPTH
//  almost_full   out  1             count >= DEPTH-AF_MARGIN
//  dout          out  DATA_WIDTH    head entry, valid when dout_valid
//  dout_valid    out  1             count != 0
//  dout_ready    in   1             consumer accepts head this cycle
//  count         out  ADDR_LEN+1    current occupancy
//  overflow      out  1             sticky overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=0, async) sets wr_ptr, rd_ptr and count to 0.
//    Outputs at reset: outbuf_full=0, almost_full=0 (1 if AF_MARGIN>=DEPTH),
//    dout_valid=0, dout=0, overflow=0.
//    Storage array is not reset. dout is forced to 0 while dout_valid=0.
//  - Write fire: outbuf_write & ~outbuf_full. Stores din at wr_ptr; wr_ptr advances.
//  - Read fire: dout_valid & dout_ready. rd_ptr advances.
//  - Pointers wrap from DEPTH-1 to 0 explicitly (no power-of-two assumption).
//  - Latency: an entry written at edge N is on dout with dout_valid=1 after edge N.
//    This applies even when the FIFO was empty: FWFT, combinational read of array[rd_ptr].
//  - Simultaneous write and read fire: count unchanged, both pointers advance.
//  - Write while full is dropped, even if a read fires in the same cycle.
//    There is no comb path from dout_ready to outbuf_full.
//  - Read while empty is ignored (dout_valid=0). A write into an empty FIFO is never
//    bypassed to the same-cycle read.
//  - clr (sync, lower priority than rst) zeroes pointers and count at the next edge.
//    Writes and reads in the same cycle as clr are discarded; overflow is also cleared.
//  - Flags (outbuf_full, almost_full, dout_valid) decode from registered count only.
//  - count never exceeds DEPTH and never underflows.
// CONFIGURATION
//  Macro PSUM_OUTBUF_OVF_STICKY_EN:
//  - Defined: overflow sets to 1 on any cycle with outbuf_write & outbuf_full.
//    It holds until rst or clr. FIFO contents are unaffected by the dropped write.
//  - Undefined: overflow is tied to 0 and no register is built.
//    Dropped writes remain silent.
// TESTING
//  1. Reset, then write 3,5,7 on consecutive cycles with dout_ready=0
//     -> count=3, dout=3, dout_valid=1, outbuf_full=0.
//  2. Fill 8 entries (0x10..0x17), then write 0x1FF while full
//     -> outbuf_full=1, count=8, drain yields 0x10..0x17.
//     overflow=1 iff PSUM_OUTBUF_OVF_STICKY_EN.
//  3. Hold dout_ready=1 and stream 20 writes, one per cycle
//     -> output order 1..20, count stays <=1, pointers wrap twice, no loss.
//  4. At count=5, write and read fire together
//     -> count stays 5; almost_full=0. Next write alone -> count=6, almost_full=1.
//  5. At count=4, pulse clr together with outbuf_write
//     -> next cycle count=0, dout_valid=0, dout=0, overflow=0.
//  6. Assert rst=0 mid-stream, asynchronously between edges
//     -> outputs go to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/psum_out_buffer.sv
// Output FIFO for PE partial sums, first-word-fall-through toward the next stage.
// Latency: an entry written at edge N appears on dout with dout_valid=1 right after edge N.
// Backpressure: outbuf_full stalls the PE (writes while full are dropped); consumer uses dout_valid/dout_ready.
// Optional macro PSUM_OUTBUF_OVF_STICKY_EN builds a sticky overflow flag for dropped writes.
module psum_out_buffer #(
    parameter int DATA_WIDTH = 17,
    parameter int DEPTH      = 8,
    parameter int ADDR_LEN   = 3,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  outbuf_write,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  outbuf_full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [ADDR_LEN:0]     count,
    output logic                  overflow
);

    localparam logic [ADDR_LEN-1:0] LAST_PTR = ADDR_LEN'(DEPTH - 1);
    localparam logic [ADDR_LEN:0]   FULL_CNT = (ADDR_LEN + 1)'(DEPTH);
    localparam int                  AF_TH    = DEPTH - AF_MARGIN;
    // A non-positive threshold means almost_full is permanently asserted.
    localparam logic [ADDR_LEN:0]   AF_TH_C  = (AF_TH > 0) ? (ADDR_LEN + 1)'(AF_TH) : '0;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_LEN-1:0]   wr_ptr;
    logic [ADDR_LEN-1:0]   rd_ptr;
    logic [ADDR_LEN:0]     count_q;
    logic                  wr_fire;
    logic                  rd_fire;

    assign outbuf_full = (count_q == FULL_CNT);
    assign almost_full = (count_q >= AF_TH_C);
    assign dout_valid  = (count_q != '0);
    assign count       = count_q;
    assign dout        = dout_valid ? mem[rd_ptr] : '0;

    assign wr_fire = outbuf_write & ~outbuf_full;
    assign rd_fire = dout_valid & dout_ready;

    always_ff @(posedge clk) begin
        if (wr_fire && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (wr_fire && !rd_fire) begin
                count_q <= count_q + 1'b1;
            end else if (rd_fire && !wr_fire) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifdef PSUM_OUTBUF_OVF_STICKY_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end else if (outbuf_write && outbuf_full) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_psum_out_buffer.sv
// Directed + randomized bench for psum_out_buffer against a queue-based reference model.
module tb_psum_out_buffer;

    localparam int DW    = 17;
    localparam int DEPTH = 8;
    localparam int AL    = 3;
    localparam int AFM   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          outbuf_write = 1'b0;
    logic [DW-1:0] din = '0;
    logic          dout_ready = 1'b0;
    logic          outbuf_full;
    logic          almost_full;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [AL:0]   count;
    logic          overflow;

    psum_out_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_LEN  (AL),
        .AF_MARGIN (AFM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .outbuf_write(outbuf_write),
        .din         (din),
        .outbuf_full (outbuf_full),
        .almost_full (almost_full),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int q[$];
    int got[$];
    bit ovf_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compare every output against the model's view of the current occupancy.
    task automatic check_state(input string tag);
        bit exp_ovf;
`ifdef PSUM_OUTBUF_OVF_STICKY_EN
        exp_ovf = ovf_m;
`else
        exp_ovf = 1'b0;
`endif
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
        chk({tag, "_valid"}, 32'(dout_valid), 32'(q.size() != 0));
        chk({tag, "_dout"},  32'(dout), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk({tag, "_full"},  32'(outbuf_full), 32'(q.size() == DEPTH));
        chk({tag, "_afull"}, 32'(almost_full), 32'(q.size() + AFM >= DEPTH));
        chk({tag, "_ovf"},   32'(overflow), 32'(exp_ovf));
    endtask

    task automatic cycle(input bit w, input int d, input bit r, input bit c);
        bit rf;
        bit wf;
        outbuf_write = w;
        din          = DW'(d);
        dout_ready   = r;
        clr          = c;
        @(negedge clk);
        check_state("cyc");
        if (c) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            rf = r && (q.size() != 0);
            wf = w && (q.size() < DEPTH);
            if (w && q.size() == DEPTH) ovf_m = 1'b1;
            if (rf) got.push_back(q.pop_front());
            if (wf) q.push_back(d & ((1 << DW) - 1));
        end
        @(posedge clk);
        #1;
        outbuf_write = 1'b0;
        dout_ready   = 1'b0;
        clr          = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout",  32'(dout), 32'd0);
        chk("rst_full",  32'(outbuf_full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Three writes, no consumer
        cycle(1'b1, 3, 1'b0, 1'b0);
        chk("t1_first_latency", 32'(dout_valid), 32'd1);
        chk("t1_first_dout", 32'(dout), 32'd3);
        cycle(1'b1, 5, 1'b0, 1'b0);
        cycle(1'b1, 7, 1'b0, 1'b0);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_dout",  32'(dout), 32'd3);
        chk("t1_full",  32'(outbuf_full), 32'd0);
        drain();

        // Fill, write while full, drain in order
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 'h10 + i, 1'b0, 1'b0);
        cycle(1'b1, 'h1FF, 1'b0, 1'b0);
        chk("t2_full",  32'(outbuf_full), 32'd1);
        chk("t2_count", 32'(count), 32'd8);
`ifdef PSUM_OUTBUF_OVF_STICKY_EN
        chk("t2_ovf", 32'(overflow), 32'd1);
`else
        chk("t2_ovf", 32'(overflow), 32'd0);
`endif
        cycle(1'b1, 'h1EE, 1'b1, 1'b0);
        chk("t2_full_rd_drop", 32'(count), 32'd7);
        got.delete();
        drain();
        chk("t2_drain_len", 32'(got.size()), 32'd7);
        for (int i = 0; i < got.size(); i++) chk("t2_drain_val", 32'(got[i]), 32'('h11 + i));

        // Streaming with consumer always ready
        got.delete();
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, i, 1'b1, 1'b0);
            chk("t3_count_le1", 32'(count <= 1), 32'd1);
        end
        cycle(1'b0, 0, 1'b1, 1'b0);
        chk("t3_len", 32'(got.size()), 32'd20);
        for (int i = 0; i < got.size(); i++) chk("t3_order", 32'(got[i]), 32'(i + 1));

        // Simultaneous read and write at count 5, then almost_full crossing
        for (int i = 0; i < 5; i++) cycle(1'b1, 'h40 + i, 1'b0, 1'b0);
        cycle(1'b1, 'h55, 1'b1, 1'b0);
        chk("t4_count", 32'(count), 32'd5);
        chk("t4_afull", 32'(almost_full), 32'd0);
        cycle(1'b1, 'h56, 1'b0, 1'b0);
        chk("t4_count6", 32'(count), 32'd6);
        chk("t4_afull6", 32'(almost_full), 32'd1);
        drain();

        // clr together with a write at count 4 (overflow set first so its clear is visible)
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 'h60 + i, 1'b0, 1'b0);
        cycle(1'b1, 'h77, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1, 1'b0);
        chk("t5_pre_count", 32'(count), 32'd4);
        cycle(1'b1, 'h99, 1'b0, 1'b1);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_valid", 32'(dout_valid), 32'd0);
        chk("t5_dout",  32'(dout), 32'd0);
        chk("t5_ovf",   32'(overflow), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, int'($urandom & 32'h1FFFF), $urandom % 2 == 1,
                  ($urandom % 50) == 0);
        end

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) cycle(1'b1, 'h100 + i, 1'b0, 1'b0);
        cycle(1'b1, 'h1AA, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(dout_valid), 32'd0);
        chk("t6_dout",  32'(dout), 32'd0);
        chk("t6_full",  32'(outbuf_full), 32'd0);
        chk("t6_afull", 32'(almost_full), 32'd0);
        chk("t6_ovf",   32'(overflow), 32'd0);
        q.delete();
        ovf_m = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        cycle(1'b1, 'h123, 1'b0, 1'b0);
        chk("t6_post_dout", 32'(dout), 32'h123);
        cycle(1'b0, 0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
